display_scan: RTL and testbench
===============================

Name: display_scan

Overview:
- Time-multiplexed scanner that drives a bank of common-anode 7-segment digits through the single hex-to-segment decoder `Decodificador`.
- Holds a NUM_DIGITS-nibble display value and selects one digit at a time.
  - Presents that digit's nibble to the decoder.
  - Asserts the matching active-low digit enable.
- Inserts a blank dead-time between digits to prevent ghosting.
- Accepts new values through a load/ack handshake, applied only at frame boundaries so a frame never tears.

Parameters:
- NUM_DIGITS, 4: number of digits scanned. Range 2..8.
- DIV, 50000: clk cycles a digit is lit (SHOW phase). Must be ≥1.
- BLANK_CYCLES, 500: clk cycles all digits are off before each SHOW. Must be ≥1.

Ports:
- clk, input, 1: single system clock.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: request to display `value`. Single-cycle pulse or held.
- value, input, 4*NUM_DIGITS: display value. Nibble i is digit i; digit 0 is least significant.
- lz_blank_en, input, 1: 1 = suppress leading-zero digits.
- nibble_out, output, 4: nibble to `Decodificador` input.
- digit_en_n, output, NUM_DIGITS: active-low digit enables. At most one bit is low.
- load_ack, output, 1: one-cycle pulse when a requested value becomes the displayed value.
- frame_done, output, 1: one-cycle pulse on the last cycle of each full scan.

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-high.
  - Port clock is `clk`, reset is `reset`.
- Reset values
  - shadow register = 0; pending flag = 0; pending value = 0.
  - digit index = 0; state = BLANK; timer = 0.
  - digit_en_n = all 1; nibble_out = 0; load_ack = 0; frame_done = 0.
  - Reset mid-frame or mid-handshake discards any pending load with no ack. The first scan starts from BLANK of digit 0 on the cycle after reset deasserts.
- All outputs are registered. The downstream decoder is combinational.
- State machine: two states, BLANK and SHOW.
  - BLANK
    - digit_en_n = all 1.
    - nibble_out = shadow nibble[index], updated on entry.
    - Stay BLANK_CYCLES cycles, then go to SHOW.
  - SHOW
    - digit_en_n[index] = 0, unless that digit is suppressed; all other bits = 1.
    - nibble_out is held stable for the whole phase.
    - Stay DIV cycles. On the last SHOW cycle:
      - If index = NUM_DIGITS-1: this is the frame boundary. index wraps to 0, frame_done pulses for that cycle, and the pending load is applied.
      - Otherwise: index increments.
    - Then go to BLANK.
- Frame length = NUM_DIGITS*(BLANK_CYCLES+DIV) cycles exactly.
- Timer
  - Counts 0 up to (phase length − 1) and resets to 0 on every phase change.
  - Width is ceil(log2(max(DIV, BLANK_CYCLES))), with a minimum of 1.
- Load handshake
  - load=1 captures value into pending value and sets pending.
  - A repeated load before the boundary overwrites the pending value; latest wins, and only one ack is issued.
  - At the frame-boundary cycle, if pending or load is 1:
    - shadow ← (load ? value : pending value).
    - pending cleared.
    - load_ack = 1 on the following cycle, concurrent with the first BLANK cycle of digit 0 that uses the new value.
  - load asserted exactly on the boundary cycle is applied in that same frame boundary.
  - A load on the cycle after the boundary waits a full frame.
- Leading-zero suppression
  - Digit i (i ≥ 1) is suppressed when lz_blank_en=1 and shadow nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - A suppressed digit still consumes its full BLANK and SHOW time, keeping brightness uniform. Its enable stays 1.
  - lz_blank_en is sampled combinationally during SHOW. Changes take effect at the next SHOW entry.

Decomposition:
- Shared package `display_pkg`:
  - scan_state_t enum {BLANK, SHOW}.
  - DIGIT_IDX_W function, computing ceil(log2(NUM_DIGITS)).
  - NIBBLE_W = 4 constant.
- Sub-module `scan_timer`: parameterised phase counter.
  - Inputs: clk, reset, restart, length select.
  - Output: last-cycle pulse.
  - Instantiated once.
- The leading-zero mask is combinational logic inside display_scan.

Test Plan:
All scenarios use NUM_DIGITS=4, DIV=4, BLANK_CYCLES=2, giving a frame of 24 cycles.
1. Reset released, no load.
   - Required: digit_en_n cycles 1111×2, 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4.
   - Required: nibble_out = 0 throughout; frame_done high on cycle 23.
2. load pulse value=16'h1A3F at cycle 5.
   - Required: load_ack on cycle 24.
   - Required: next frame nibble_out sequence F, 3, A, 1, each held 6 cycles (BLANK+SHOW).
3. Loads of 16'h1111 at cycle 3 and 16'h2222 at cycle 10.
   - Required: single load_ack at cycle 24.
   - Required: displayed value 16'h2222.
4. lz_blank_en=1, value 16'h0050.
   - Required: digits 0 and 1 lit.
   - Required: digit_en_n stays 1111 during SHOW of digits 2 and 3; frame length still 24.
5. lz_blank_en=1, value 16'h0000.
   - Required: only digit 0 lit with nibble 0.
6. load on the boundary cycle 23, then reset asserted at cycle 30 with load pending from cycle 28.
   - Required: boundary load acked at cycle 24.
   - Required: after reset, no ack, shadow = 0, scan restarts at BLANK of digit 0.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and helpers for the multiplexed 7-segment scanner.
//   scan_state_t : scan phase (BLANK dead-time / SHOW digit lit)
//   NIBBLE_W     : bits per displayed hex digit
//   DIGIT_IDX_W  : width of a digit index for a given digit count
//   TIMER_W      : width of a phase counter covering two phase lengths
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int NIBBLE_W = 4;

    // ceil(log2(n)), never narrower than one bit.
    function automatic int DIGIT_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // ceil(log2(max(a, b))), never narrower than one bit. The counter only
    // reaches (length - 1), so this width is always sufficient.
    function automatic int TIMER_W(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Phase counter for the display scanner. Counts 0 .. (length - 1) of the
// current phase and restarts from 0 whenever restart_i is high.
//
// Ports
//   clk         : system clock
//   reset       : synchronous, active-high reset (counter 0, phase A)
//   restart_i   : the current cycle ends the phase; next cycle counts from 0
//   sel_i       : length of the phase the next cycle belongs to
//                 (0 = LEN_A, 1 = LEN_B)
//   last_o      : registered, high during the last cycle of the phase
//   last_next_o : combinational look-ahead, high when the next cycle will be
//                 the last cycle of its phase
// -----------------------------------------------------------------------------
module scan_timer
    import display_pkg::*;
#(
    parameter int LEN_A = 2,
    parameter int LEN_B = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    input  logic sel_i,
    output logic last_o,
    output logic last_next_o
);

    localparam int TW = TIMER_W(LEN_A, LEN_B);
    localparam logic [TW-1:0] LAST_A = TW'(LEN_A - 1);
    localparam logic [TW-1:0] LAST_B = TW'(LEN_B - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;
    logic          last_q;

    always_comb begin
        count_d     = restart_i ? '0 : count_q + TW'(1);
        last_next_o = (count_d == (sel_i ? LAST_B : LAST_A));
    end

    // last_q is precomputed one cycle ahead so the "last" flag is a flop and
    // the phase machine in the parent can react to it without a long path.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            last_q  <= (LAST_A == '0);
        end else begin
            count_q <= count_d;
            last_q  <= last_next_o;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/display_scan.sv
// -----------------------------------------------------------------------------
// display_scan
// Time-multiplexed scanner for a bank of common-anode 7-segment digits that
// share one combinational hex-to-segment decoder. Each digit gets a BLANK
// dead-time (all digits off, nibble switched) followed by a SHOW phase (its
// enable low). New values are taken through a load/ack handshake and only
// applied at the frame boundary so a frame never mixes two values.
//
// Ports
//   clk         : system clock
//   reset       : synchronous, active-high reset
//   load        : request to display `value` (pulse or held)
//   value       : display value, nibble i drives digit i (digit 0 = LSD)
//   lz_blank_en : 1 = leading zero digits stay dark
//   nibble_out  : nibble for the decoder (registered)
//   digit_en_n  : active-low digit enables, at most one low (registered)
//   load_ack    : one-cycle pulse when a requested value becomes displayed
//   frame_done  : one-cycle pulse on the last cycle of every full scan
// -----------------------------------------------------------------------------
module display_scan
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
    input  logic                           lz_blank_en,
    output logic [NIBBLE_W-1:0]            nibble_out,
    output logic [NUM_DIGITS-1:0]          digit_en_n,
    output logic                           load_ack,
    output logic                           frame_done
);

    localparam int IW = DIGIT_IDX_W(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] nibbles_t;

    // Display value registers
    nibbles_t              shadow_q,   shadow_d;
    nibbles_t              pend_val_q, pend_val_d;
    logic                  pending_q,  pending_d;

    // Scan position
    scan_state_t           state_q,    state_d;
    logic [IW-1:0]         index_q,    index_d;

    // Registered outputs
    logic [NIBBLE_W-1:0]   nibble_q,   nibble_d;
    logic [NUM_DIGITS-1:0] en_n_q,     en_n_d;
    logic                  ack_q,      ack_d;
    logic                  fdone_q,    fdone_d;

    // Timer interface
    logic                  phase_last;
    logic                  next_last;
    logic                  sel_show;
    logic                  boundary;

    logic [NUM_DIGITS-1:0] suppress;

    // -------------------------------------------------------------------------
    // Leading-zero mask: digit i is dark when every nibble from i upward is 0.
    // Digit 0 is always shown so a zero value still displays "0".
    // -------------------------------------------------------------------------
    assign suppress[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign suppress[gi] = lz_blank_en &&
                                  (shadow_q[NUM_DIGITS-1:gi] == '0);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Phase timer. The length selected is that of the phase the next cycle
    // belongs to, so it counts BLANK_CYCLES or DIV from the first cycle on.
    // -------------------------------------------------------------------------
    assign sel_show = (state_d == SHOW);

    scan_timer #(
        .LEN_A (BLANK_CYCLES),
        .LEN_B (DIV)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .restart_i   (phase_last),
        .sel_i       (sel_show),
        .last_o      (phase_last),
        .last_next_o (next_last)
    );

    // Last SHOW cycle of the highest digit: the only point where the
    // displayed value may change.
    assign boundary = (state_q == SHOW) && phase_last && (index_q == LAST_IDX);

    always_comb begin
        shadow_d   = shadow_q;
        pend_val_d = pend_val_q;
        pending_d  = pending_q;
        state_d    = state_q;
        index_d    = index_q;
        nibble_d   = nibble_q;
        en_n_d     = en_n_q;
        ack_d      = 1'b0;
        fdone_d    = 1'b0;

        // Handshake. A load arriving on the boundary cycle itself is taken
        // directly, so it wins over an older pending value.
        if (boundary) begin
            pending_d = 1'b0;
            if (load) begin
                shadow_d = nibbles_t'(value);
                ack_d    = 1'b1;
            end else if (pending_q) begin
                shadow_d = pend_val_q;
                ack_d    = 1'b1;
            end
        end else if (load) begin
            pending_d  = 1'b1;
            pend_val_d = nibbles_t'(value);
        end

        // Phase sequencing. Outputs are computed from the next-state values so
        // that they line up with the state they describe.
        if (phase_last) begin
            if (state_q == BLANK) begin
                state_d = SHOW;
                if (suppress[index_q]) begin
                    en_n_d = '1;
                end else begin
                    en_n_d = ~(NUM_DIGITS'(1) << index_q);
                end
            end else begin
                state_d  = BLANK;
                index_d  = (index_q == LAST_IDX) ? '0 : index_q + IW'(1);
                en_n_d   = '1;
                nibble_d = shadow_d[index_d];
            end
        end

        // Flag the final cycle of the frame one cycle early so it is a flop.
        fdone_d = (state_d == SHOW) && next_last && (index_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q   <= '0;
            pend_val_q <= '0;
            pending_q  <= 1'b0;
            state_q    <= BLANK;
            index_q    <= '0;
            nibble_q   <= '0;
            en_n_q     <= '1;
            ack_q      <= 1'b0;
            fdone_q    <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            pend_val_q <= pend_val_d;
            pending_q  <= pending_d;
            state_q    <= state_d;
            index_q    <= index_d;
            nibble_q   <= nibble_d;
            en_n_q     <= en_n_d;
            ack_q      <= ack_d;
            fdone_q    <= fdone_d;
        end
    end

    assign nibble_out = nibble_q;
    assign digit_en_n = en_n_q;
    assign load_ack   = ack_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_display_scan.sv
// -----------------------------------------------------------------------------
// tb_display_scan
// Directed bench for display_scan with NUM_DIGITS=4, DIV=4, BLANK_CYCLES=2
// (24-cycle frame: each digit gets 2 dark cycles then 4 lit cycles).
// Cycle 0 is the first cycle after reset is released.
// -----------------------------------------------------------------------------
module tb_display_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        lz_blank_en;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_en_n;
    logic        load_ack;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Enables of each digit during SHOW, digit 3 in the top nibble.
    localparam logic [15:0] EN_ALL  = 16'h7BDE;
    localparam logic [15:0] EN_D0   = 16'hFFFE;

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [15:0] en_tab;
    } vec_t;

    vec_t vecs [6];

    display_scan #(
        .NUM_DIGITS   (4),
        .DIV          (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .lz_blank_en (lz_blank_en),
        .nibble_out  (nibble_out),
        .digit_en_n  (digit_en_n),
        .load_ack    (load_ack),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b1;
        value = 16'hFFFF;
        tick();
        tick();
        checks++;
        if (digit_en_n !== 4'hF || nibble_out !== 4'h0 ||
            load_ack !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state en=%b nib=%h ack=%b fd=%b want en=1111 nib=0 ack=0 fd=0",
                     digit_en_n, nibble_out, load_ack, frame_done);
        end
        reset = 1'b0;
        load  = 1'b0;
    endtask

    // Expected outputs for cycle c of a steady scan showing `shown`.
    task automatic check_cycle(input string tag, input int c,
                               input logic [15:0] shown,
                               input logic [15:0] en_tab,
                               input logic exp_ack);
        int         pos;
        int         d;
        logic [3:0] exp_en;
        logic [3:0] exp_nib;
        logic       exp_fd;
        pos     = c % 24;
        d       = pos / 6;
        exp_en  = ((pos % 6) < 2) ? 4'hF : en_tab[d*4 +: 4];
        exp_nib = shown[d*4 +: 4];
        exp_fd  = (pos == 23);
        checks++;
        if (digit_en_n !== exp_en || nibble_out !== exp_nib ||
            load_ack !== exp_ack || frame_done !== exp_fd) begin
            errors++;
            $display("FAIL %s cyc=%0d got en=%b nib=%h ack=%b fd=%b want en=%b nib=%h ack=%b fd=%b",
                     tag, c, digit_en_n, nibble_out, load_ack, frame_done,
                     exp_en, exp_nib, exp_ack, exp_fd);
        end
    endtask

    initial begin
        reset       = 1'b1;
        load        = 1'b0;
        value       = 16'h0000;
        lz_blank_en = 1'b0;

        vecs[0] = '{value: 16'h1A3F, lz: 1'b0, en_tab: 16'h7BDE};
        vecs[1] = '{value: 16'h0050, lz: 1'b1, en_tab: 16'hFFDE};
        vecs[2] = '{value: 16'h0000, lz: 1'b1, en_tab: 16'hFFFE};
        vecs[3] = '{value: 16'h0000, lz: 1'b0, en_tab: 16'h7BDE};
        vecs[4] = '{value: 16'h8001, lz: 1'b1, en_tab: 16'h7BDE};
        vecs[5] = '{value: 16'h0300, lz: 1'b1, en_tab: 16'hFBDE};

        // Idle scan after reset: zero shown, no ack, frame_done at 23 and 47.
        do_reset();
        for (int c = 0; c < 48; c++) begin
            check_cycle("idle", c, 16'h0000, EN_ALL, 1'b0);
            tick();
        end
        $display("idle scan: 48 cycles checked");

        // Table: load at cycle 0, ack at 24, new value scanned in frame 1.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            lz_blank_en = vecs[i].lz;
            value       = vecs[i].value;
            for (int c = 0; c < 48; c++) begin
                load = (c == 0);
                if (c < 24) begin
                    check_cycle("vec_f0", c, 16'h0000,
                                vecs[i].lz ? EN_D0 : EN_ALL, 1'b0);
                end else begin
                    check_cycle("vec_f1", c, vecs[i].value, vecs[i].en_tab,
                                c == 24);
                end
                tick();
            end
            load = 1'b0;
            $display("vector %0d: value=%h lz=%b", i, vecs[i].value, vecs[i].lz);
        end
        lz_blank_en = 1'b0;

        // Two loads in one frame: latest wins, a single ack.
        do_reset();
        for (int c = 0; c < 48; c++) begin
            load  = (c == 3) || (c == 10);
            value = (c == 3) ? 16'h1111 : 16'h2222;
            check_cycle("latest_wins", c, (c < 24) ? 16'h0000 : 16'h2222,
                        EN_ALL, c == 24);
            tick();
        end
        load = 1'b0;
        $display("double load: displayed 2222");

        // Load on the boundary cycle, then reset with a load still pending.
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            load  = (c == 23) || (c == 28);
            value = (c == 23) ? 16'h4C2D : 16'hBEEF;
            check_cycle("boundary_load", c, (c < 24) ? 16'h0000 : 16'h4C2D,
                        EN_ALL, c == 24);
            if (c == 30) begin
                reset = 1'b1;
                load  = 1'b0;
            end
            tick();
        end
        reset = 1'b0;
        for (int c = 0; c < 48; c++) begin
            check_cycle("post_reset", c, 16'h0000, EN_ALL, 1'b0);
            tick();
        end
        $display("boundary load then reset: pending discarded");

        // Load just after the boundary waits a whole frame.
        do_reset();
        for (int c = 0; c < 72; c++) begin
            load  = (c == 24);
            value = 16'h5678;
            check_cycle("late_load", c, (c < 48) ? 16'h0000 : 16'h5678,
                        EN_ALL, c == 48);
            tick();
        end
        load = 1'b0;
        $display("late load: acked one frame later");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
